// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and conversion FSM state type for the display scanner
package disp_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int NUM_DIGITS = 4;
  localparam logic [13:0] MAX_MV = 14'd9999;
  localparam int CONV_CYCLES = 14;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle
// ports: clk, reset (async high), start (capture bin_in), bin_in[13:0],
//        done (high during the final shift), bcd_out[15:0] (valid the cycle after done)
module bin2bcd_seq import disp_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        done,
  output logic [15:0] bcd_out
);
  logic [13:0] bin;
  logic [15:0] adj;
  logic [3:0]  cnt;
  logic        active;
  always_comb begin
    adj = bcd_out;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[i*4+:4] = bcd_out[i*4+:4] >= 4'd5 ? bcd_out[i*4+:4] + 4'd3 : bcd_out[i*4+:4];
  end
  // done flags the last iteration so the owner can leave SHIFT on the same edge
  assign done = active && cnt == 4'(CONV_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bin     <= '0;
      bcd_out <= '0;
      cnt     <= '0;
      active  <= 1'b0;
    end else if (start) begin
      bin     <= bin_in;
      bcd_out <= '0;
      cnt     <= '0;
      active  <= 1'b1;
    end else if (active) begin
      {bcd_out, bin} <= {adj, bin} << 1;
      cnt            <= cnt + 4'd1;
      active         <= !done;
    end
endmodule

// File: rtl/display_scanner.sv
// display_scanner: mV reading to BCD, latched and time-multiplexed onto a 4-digit display
// ports: clk, reset (async high), value_mv[13:0] + load (start strobe), busy,
//        digit_data[3:0] (4'hF = blank), anode[3:0] (active-low one-hot), dp (active-low)
module display_scanner import disp_pkg::*; #(
  parameter int REFRESH_DIV   = 4096,
  parameter int DP_POS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value_mv,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit_data,
  output logic [3:0]  anode,
  output logic        dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  conv_state_t   state;
  logic          over, start, done, lead, term;
  logic [15:0]   bcd, shown, disp;
  logic [CW-1:0] rcnt;
  logic [1:0]    idx, idx_n;
  assign start = state == IDLE && load;
  bin2bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (value_mv),
    .done    (done),
    .bcd_out (bcd)
  );
  // lead stays set only while every digit from the top down is zero and left of the point
  always_comb begin
    shown = bcd;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead = lead && bcd[i*4+:4] == 4'd0 && i > DP_POS;
      if (BLANK_LEADING != 0 && lead) shown[i*4+:4] = BLANK_CODE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      over  <= 1'b0;
      disp  <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      case (state)
        IDLE: if (load) begin
          state <= SHIFT;
          busy  <= 1'b1;
          over  <= value_mv > MAX_MV;
        end
        SHIFT: if (done) state <= COMMIT;
        COMMIT: begin
          disp  <= over ? {NUM_DIGITS{BLANK_CODE}} : shown;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign term  = rcnt == CW'(REFRESH_DIV - 1);
  assign idx_n = term ? idx + 2'd1 : idx;
  // outputs are driven from the next index so all three switch on the same edge as idx
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rcnt       <= '0;
      idx        <= '0;
      anode      <= 4'b1110;
      digit_data <= BLANK_CODE;
      dp         <= DP_POS != 0;
    end else begin
      rcnt       <= term ? '0 : rcnt + CW'(1);
      idx        <= idx_n;
      anode      <= ~(4'b1 << idx_n);
      digit_data <= disp[idx_n*4+:4];
      dp         <= idx_n != 2'(DP_POS);
    end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed + random checks of two display_scanner configurations against a digit model
module tb_display_scanner;
  localparam int R = 4;
  logic clk = 0, reset = 0, load = 0;
  logic [13:0] value_mv = '0;
  logic busy0, busy1, dp0, dp1;
  logic [3:0] dd0, dd1, an0, an1;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] e0 = 16'hFFFF, e1 = 16'hFFFF;
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  display_scanner #(.REFRESH_DIV(R), .DP_POS(3), .BLANK_LEADING(1)) u0 (
    .clk(clk), .reset(reset), .value_mv(value_mv), .load(load),
    .busy(busy0), .digit_data(dd0), .anode(an0), .dp(dp0));
  display_scanner #(.REFRESH_DIV(R), .DP_POS(0), .BLANK_LEADING(1)) u1 (
    .clk(clk), .reset(reset), .value_mv(value_mv), .load(load),
    .busy(busy1), .digit_data(dd1), .anode(an1), .dp(dp1));
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // displayed digits: significant digits of v, padded with zeros up to the point position
  function automatic logic [15:0] model(int v, int dpp);
    logic [15:0] r = 16'hFFFF;
    int nd = 1;
    int d = v;
    if (v > 9999) return r;
    while (d >= 10) begin
      nd++;
      d /= 10;
    end
    d = v;
    for (int i = 0; i < 4; i++) begin
      if (i < nd || i <= dpp) r[i*4+:4] = 4'(d % 10);
      d /= 10;
    end
    return r;
  endfunction
  function automatic int cur_idx();
    return (cyc / R) % 4;
  endfunction
  task automatic scan_chk(string tag, int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      logic [3:0] ea;
      @(posedge clk);
      #1;
      idx = cur_idx();
      ea = ~(4'b1 << idx);
      chk({tag, ".an0"}, an0, ea);
      chk({tag, ".an1"}, an1, ea);
      chk({tag, ".dd0"}, dd0, e0[idx*4+:4]);
      chk({tag, ".dd1"}, dd1, e1[idx*4+:4]);
      chk({tag, ".dp0"}, dp0, idx != 3);
      chk({tag, ".dp1"}, dp1, idx != 0);
    end
  endtask
  task automatic do_load(int v, int ld2, int v2);
    logic [15:0] o0 = e0, o1 = e1;
    int idx;
    @(negedge clk);
    value_mv = 14'(v);
    load = 1;
    @(posedge clk);
    #1;
    load = 0;
    for (int i = 0; i < 15; i++) begin
      chk("busy0_hi", busy0, 1);
      chk("busy1_hi", busy1, 1);
      if (i == ld2) begin
        value_mv = 14'(v2);
        load = 1;
      end
      @(posedge clk);
      #1;
      load = 0;
    end
    chk("busy0_lo", busy0, 0);
    chk("busy1_lo", busy1, 0);
    idx = cur_idx();
    chk("hold0", dd0, o0[idx*4+:4]);
    chk("hold1", dd1, o1[idx*4+:4]);
    e0 = model(v, 3);
    e1 = model(v, 0);
    @(posedge clk);
    #1;
    idx = cur_idx();
    chk("upd0", dd0, e0[idx*4+:4]);
    chk("upd1", dd1, e1[idx*4+:4]);
  endtask
  initial begin
    #1 reset = 1;
    #2;
    chk("rst_an0", an0, 4'b1110);
    chk("rst_dd0", dd0, 4'hF);
    chk("rst_busy0", busy0, 0);
    chk("rst_dp0", dp0, 1);
    chk("rst_dp1", dp1, 0);
    chk("rst_dd1", dd1, 4'hF);
    @(negedge clk);
    reset = 0;
    scan_chk("idle", 8);
    do_load(1234, -1, 0);
    scan_chk("v1234", 16);
    do_load(5, -1, 0);
    scan_chk("v5", 16);
    do_load(10000, -1, 0);
    scan_chk("over", 16);
    do_load(9999, -1, 0);
    scan_chk("v9999", 16);
    do_load(0, -1, 0);
    scan_chk("v0", 16);
    do_load(1234, 0, 5678);
    do_load(1234, 5, 5678);
    scan_chk("ignored", 16);
    @(negedge clk);
    value_mv = 14'd4321;
    load = 1;
    @(posedge clk);
    #1 load = 0;
    repeat (7) @(posedge clk);
    #2 reset = 1;
    #1;
    e0 = 16'hFFFF;
    e1 = 16'hFFFF;
    chk("arst_an0", an0, 4'b1110);
    chk("arst_dd0", dd0, 4'hF);
    chk("arst_busy0", busy0, 0);
    chk("arst_dd1", dd1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    chk("rsthold_dd0", dd0, 4'hF);
    chk("rsthold_busy0", busy0, 0);
    @(negedge clk);
    reset = 0;
    scan_chk("post_rst", 8);
    do_load(42, -1, 0);
    scan_chk("v42", 16);
    repeat (8) begin
      int v;
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 16383);
      do_load(v, $urandom_range(0, 20) - 3, $urandom_range(0, 16383));
      scan_chk("rand", 16);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
